uut_vector_sequencer: RTL and testbench

UUT_VECTOR_SEQUENCER -- requirements
Module: uut_vector_sequencer

---
 rtl/autotest_pkg.sv | 22 ++
 rtl/uut_vector_sequencer_byte_shift_reg.sv | 30 +++
 rtl/uut_vector_sequencer.sv | 160 ++++++++++++++++
 tb/tb_uut_vector_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/autotest_pkg.sv
// Shared FSM state type, default interface sizes and the saturating counter helper
// used by the UUT vector sequencer.
package autotest_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    SEND   = 2'd3
  } seq_state_t;

  localparam int DEF_INPUT_SIZE_1   = 128;
  localparam int DEF_INPUT_SIZE_2   = 128;
  localparam int DEF_INPUT_SIZE_3   = 8;
  localparam int DEF_OUTPUT_SIZE_1  = 128;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/uut_vector_sequencer_byte_shift_reg.sv
// Byte-wide shift register with parallel load; bytes enter at the LSB end and
// leave from the MSB end. TAP_W exposes the top TAP_W bits of the register.
module byte_shift_reg #(
  parameter int WIDTH = 128,
  parameter int TAP_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic [7:0]       byte_in,
  output logic [TAP_W-1:0] tap
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= (sr << 8) | WIDTH'(byte_in);
    end
  end

  assign tap = sr[WIDTH-1 -: TAP_W];

endmodule

// File: rtl/uut_vector_sequencer.sv
// Streams one test vector into a UUT, resets and runs it, then streams the
// captured result back out byte by byte, keeping latency and vector statistics.
module uut_vector_sequencer
  import autotest_pkg::*;
#(
  parameter int INPUT_SIZE_1   = DEF_INPUT_SIZE_1,
  parameter int INPUT_SIZE_2   = DEF_INPUT_SIZE_2,
  parameter int INPUT_SIZE_3   = DEF_INPUT_SIZE_3,
  parameter int OUTPUT_SIZE_1  = DEF_OUTPUT_SIZE_1,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid_i,
  output logic                     byte_ready_o,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  output logic                     rst_uut,
  output logic [INPUT_SIZE_1-1:0]  input_to_UUT_1,
  output logic [INPUT_SIZE_2-1:0]  input_to_UUT_2,
  output logic [INPUT_SIZE_3-1:0]  input_to_UUT_3,
  input  logic [OUTPUT_SIZE_1-1:0] output_from_UUT_1,
  input  logic                     end_uut,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [15:0]              vector_count_o,
  output logic [31:0]              last_latency_o
);

  localparam int IN_W   = INPUT_SIZE_1 + INPUT_SIZE_2 + INPUT_SIZE_3;
  localparam int NIN    = IN_W / 8;
  localparam int NOUT   = OUTPUT_SIZE_1 / 8;
  localparam int INC_W  = $clog2(NIN + 1);
  localparam int OUTC_W = $clog2(NOUT + 1);

  localparam logic [INC_W-1:0]  IN_LAST  = INC_W'(NIN - 1);
  localparam logic [OUTC_W-1:0] OUT_LAST = OUTC_W'(NOUT - 1);
  localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  seq_state_t state_q, state_d;

  logic [INC_W-1:0]  in_cnt;
  logic [OUTC_W-1:0] out_cnt;
  logic              launch_cnt;
  logic [31:0]       cycle_cnt;
  logic [IN_W-1:0]   in_data;

  logic in_fire, in_last, out_fire, out_last;
  logic run_end, run_timeout;

  assign in_fire     = (state_q == LOAD) && byte_ready_o && byte_valid_i;
  assign in_last     = in_fire && (in_cnt == IN_LAST);
  assign out_fire    = (state_q == SEND) && byte_ready_i;
  assign out_last    = out_fire && (out_cnt == OUT_LAST);
  assign run_end     = (state_q == RUN) && end_uut;
  assign run_timeout = (state_q == RUN) && !end_uut && (cycle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_uut      = 1'b1;
    busy_o       = 1'b1;
    byte_valid_o = 1'b0;
    case (state_q)
      LOAD: begin
        busy_o = 1'b0;
        if (in_last) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (launch_cnt) state_d = RUN;
      end
      RUN: begin
        rst_uut = 1'b0;
        if (run_end || run_timeout) state_d = SEND;
      end
      SEND: begin
        rst_uut      = 1'b0;
        byte_valid_o = 1'b1;
        if (out_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Ready is registered so it stays low through reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready_o   <= 1'b0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      launch_cnt     <= 1'b0;
      cycle_cnt      <= '0;
      timeout_o      <= 1'b0;
      vector_count_o <= '0;
      last_latency_o <= '0;
    end else begin
      byte_ready_o <= (state_d == LOAD);

      if (in_fire) begin
        in_cnt <= in_last ? '0 : in_cnt + INC_W'(1);
      end

      if (out_fire) begin
        out_cnt <= out_last ? '0 : out_cnt + OUTC_W'(1);
      end

      launch_cnt <= (state_q == LAUNCH) ? !launch_cnt : 1'b0;
      cycle_cnt  <= (state_q == RUN) ? sat_inc32(cycle_cnt) : '0;

      if (run_end) begin
        last_latency_o <= cycle_cnt;
        vector_count_o <= vector_count_o + 16'd1;
      end else if (run_timeout) begin
        timeout_o      <= 1'b1;
        last_latency_o <= 32'hFFFF_FFFF;
      end
    end
  end

  // Inbound bytes shift in MSB-first, so the first byte lands at the top of block.
  byte_shift_reg #(
    .WIDTH (IN_W),
    .TAP_W (IN_W)
  ) u_in_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_fire),
    .byte_in   (byte_i),
    .tap       (in_data)
  );

  assign input_to_UUT_1 = in_data[IN_W-1 -: INPUT_SIZE_1];
  assign input_to_UUT_2 = in_data[INPUT_SIZE_2+INPUT_SIZE_3-1 -: INPUT_SIZE_2];
  assign input_to_UUT_3 = in_data[INPUT_SIZE_3-1:0];

  byte_shift_reg #(
    .WIDTH (OUTPUT_SIZE_1),
    .TAP_W (8)
  ) u_out_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (run_end || run_timeout),
    .load_data (output_from_UUT_1),
    .shift     (out_fire),
    .byte_in   (8'h00),
    .tap       (byte_o)
  );

endmodule

// File: tb/tb_uut_vector_sequencer.sv
// Bench for uut_vector_sequencer with a stub UUT (result = block ^ key, end_uut
// five cycles after rst_uut falls) and a byte-level reference model.
module tb_uut_vector_sequencer;

  localparam int IN1  = 128;
  localparam int IN2  = 128;
  localparam int IN3  = 8;
  localparam int OUT1 = 128;
  localparam int TO   = 20;
  localparam int NIN  = (IN1 + IN2 + IN3) / 8;
  localparam int NOUT = OUT1 / 8;
  localparam int NBLK = IN1 / 8;
  localparam int LAT  = 5;

  typedef logic [7:0] vec_t [NIN];

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      byte_i = 8'h00;
  logic            byte_valid_i = 1'b0;
  logic            byte_ready_o;
  logic [7:0]      byte_o;
  logic            byte_valid_o;
  logic            byte_ready_i = 1'b0;
  logic            rst_uut;
  logic [IN1-1:0]  input_to_UUT_1;
  logic [IN2-1:0]  input_to_UUT_2;
  logic [IN3-1:0]  input_to_UUT_3;
  logic [OUT1-1:0] output_from_UUT_1;
  logic            end_uut;
  logic            busy_o;
  logic            timeout_o;
  logic [15:0]     vector_count_o;
  logic [31:0]     last_latency_o;

  logic [3:0]  stub_cnt;
  logic        stub_en = 1'b1;
  logic        end_force = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;
  logic        exp_timeout = 1'b0;

  always #5 clk = ~clk;

  uut_vector_sequencer #(
    .INPUT_SIZE_1   (IN1),
    .INPUT_SIZE_2   (IN2),
    .INPUT_SIZE_3   (IN3),
    .OUTPUT_SIZE_1  (OUT1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .byte_i            (byte_i),
    .byte_valid_i      (byte_valid_i),
    .byte_ready_o      (byte_ready_o),
    .byte_o            (byte_o),
    .byte_valid_o      (byte_valid_o),
    .byte_ready_i      (byte_ready_i),
    .rst_uut           (rst_uut),
    .input_to_UUT_1    (input_to_UUT_1),
    .input_to_UUT_2    (input_to_UUT_2),
    .input_to_UUT_3    (input_to_UUT_3),
    .output_from_UUT_1 (output_from_UUT_1),
    .end_uut           (end_uut),
    .busy_o            (busy_o),
    .timeout_o         (timeout_o),
    .vector_count_o    (vector_count_o),
    .last_latency_o    (last_latency_o)
  );

  // Stub UUT: counts cycles since rst_uut fell.
  always_ff @(posedge clk) begin
    if (rst_uut) stub_cnt <= 4'd0;
    else if (stub_cnt != 4'hF) stub_cnt <= stub_cnt + 4'd1;
  end
  assign end_uut = (stub_en && !rst_uut && (stub_cnt == 4'(LAT))) || end_force;
  assign output_from_UUT_1 = input_to_UUT_1 ^ input_to_UUT_2;

  function automatic logic [263:0] pack(input vec_t v, input int first, input int n);
    logic [263:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = (r << 8) | 264'(v[first + i]);
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input vec_t v, input int k);
    return v[k] ^ v[NBLK + k];
  endfunction

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " byte_ready_o"}, 264'(byte_ready_o), 264'(0));
    chk({tag, " byte_valid_o"}, 264'(byte_valid_o), 264'(0));
    chk({tag, " byte_o"}, 264'(byte_o), 264'(0));
    chk({tag, " rst_uut"}, 264'(rst_uut), 264'(1));
    chk({tag, " busy_o"}, 264'(busy_o), 264'(0));
    chk({tag, " timeout_o"}, 264'(timeout_o), 264'(0));
    chk({tag, " vector_count_o"}, 264'(vector_count_o), 264'(0));
    chk({tag, " last_latency_o"}, 264'(last_latency_o), 264'(0));
    chk({tag, " in1"}, 264'(input_to_UUT_1), 264'(0));
    chk({tag, " in2"}, 264'(input_to_UUT_2), 264'(0));
    chk({tag, " in3"}, 264'(input_to_UUT_3), 264'(0));
  endtask

  task automatic chk_inputs(input string tag, input vec_t v);
    chk({tag, " in1"}, 264'(input_to_UUT_1), pack(v, 0, IN1 / 8));
    chk({tag, " in2"}, 264'(input_to_UUT_2), pack(v, IN1 / 8, IN2 / 8));
    chk({tag, " in3"}, 264'(input_to_UUT_3), pack(v, (IN1 + IN2) / 8, IN3 / 8));
  endtask

  task automatic push_bytes(input vec_t v, input int n, input bit gappy);
    int   idx   = 0;
    int   guard = 0;
    bit   phase = 1'b0;
    logic vld;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      vld = gappy ? phase : 1'b1;
      phase = !phase;
      byte_valid_i = vld;
      byte_i = vld ? v[idx] : 8'($urandom);
      if (vld && byte_ready_o) idx++;
    end
    chk("push bound", 264'(idx), 264'(n));
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic finish_vector(input vec_t v, input int stall_at, input bit timed_out, input string tag);
    int n       = 0;
    int guard   = 0;
    int stall   = 10;
    int run_cyc = 0;
    chk({tag, " launch ready"}, 264'(byte_ready_o), 264'(0));
    chk({tag, " launch busy"}, 264'(busy_o), 264'(1));
    chk({tag, " launch rst_uut"}, 264'(rst_uut), 264'(1));
    chk_inputs({tag, " launch"}, v);
    @(negedge clk);
    chk({tag, " launch2 rst_uut"}, 264'(rst_uut), 264'(1));
    while (n < NOUT && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (busy_o && !rst_uut && !byte_valid_o) run_cyc++;
      if (byte_valid_o) begin
        byte_valid_i = 1'b0;
        if (n == stall_at && stall > 0) begin
          byte_ready_i = 1'b0;
          chk({tag, " stalled byte"}, 264'(byte_o), 264'(exp_byte(v, n)));
          stall--;
        end else begin
          byte_ready_i = 1'b1;
          chk({tag, " out byte"}, 264'(byte_o), 264'(exp_byte(v, n)));
          n++;
        end
      end else begin
        byte_ready_i = 1'b0;
        byte_valid_i = 1'($urandom);
        byte_i = 8'($urandom);
      end
    end
    chk({tag, " send bound"}, 264'(n), 264'(NOUT));
    @(negedge clk);
    byte_ready_i = 1'b0;
    byte_valid_i = 1'b0;
    if (timed_out) exp_timeout = 1'b1;
    else exp_count = exp_count + 16'd1;
    chk({tag, " end valid_o"}, 264'(byte_valid_o), 264'(0));
    chk({tag, " end rst_uut"}, 264'(rst_uut), 264'(1));
    chk({tag, " end busy"}, 264'(busy_o), 264'(0));
    chk({tag, " end ready"}, 264'(byte_ready_o), 264'(1));
    chk({tag, " run cycles"}, 264'(run_cyc), timed_out ? 264'(TO) : 264'(LAT + 1));
    chk({tag, " latency"}, 264'(last_latency_o), timed_out ? 264'(32'hFFFF_FFFF) : 264'(LAT));
    chk({tag, " count"}, 264'(vector_count_o), 264'(exp_count));
    chk({tag, " timeout"}, 264'(timeout_o), 264'(exp_timeout));
    chk_inputs({tag, " held"}, v);
  endtask

  initial begin
    vec_t v;

    #13;
    chk_reset_values("por");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release ready pre-edge", 264'(byte_ready_o), 264'(0));
    @(negedge clk);
    chk("release ready first edge", 264'(byte_ready_o), 264'(1));
    chk("idle rst_uut", 264'(rst_uut), 264'(1));

    for (int i = 0; i < 32; i++) v[i] = 8'(i);
    v[32] = 8'h01;
    push_bytes(v, NIN, 1'b0);
    finish_vector(v, -1, 1'b0, "v1");

    @(negedge clk);
    end_force = 1'b1;
    @(negedge clk);
    end_force = 1'b0;
    chk("load end_uut busy", 264'(busy_o), 264'(0));
    chk("load end_uut count", 264'(vector_count_o), 264'(exp_count));
    chk("load end_uut latency", 264'(last_latency_o), 264'(LAT));
    chk("load end_uut ready", 264'(byte_ready_o), 264'(1));

    push_bytes(v, NIN, 1'b1);
    finish_vector(v, -1, 1'b0, "v2 gappy");

    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, NIN, 1'b0);
    finish_vector(v, int'($urandom_range(0, NOUT - 1)), 1'b0, "v3 stall");

    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, NIN, 1'b1);
    finish_vector(v, -1, 1'b0, "v4");

    stub_en = 1'b0;
    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, NIN, 1'b0);
    finish_vector(v, 0, 1'b1, "v5 timeout");
    stub_en = 1'b1;

    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, NIN, 1'b0);
    finish_vector(v, -1, 1'b0, "v6 sticky");

    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, 10, 1'b0);
    #2 rst = 1'b0;
    #1;
    exp_count = 16'd0;
    exp_timeout = 1'b0;
    chk_reset_values("load rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, NIN, 1'b0);
    chk_inputs("v7 after partial", v);
    repeat (3) @(negedge clk);
    chk("v7 in run busy", 264'(busy_o), 264'(1));
    chk("v7 in run rst_uut", 264'(rst_uut), 264'(0));
    #2 rst = 1'b0;
    #1;
    chk_reset_values("run rst");
    repeat (3) begin
      @(negedge clk);
      chk("run rst no byte", 264'(byte_valid_o), 264'(0));
    end
    rst = 1'b1;
    #1;
    chk("run rst release ready", 264'(byte_ready_o), 264'(0));
    @(negedge clk);
    chk("run rst first edge ready", 264'(byte_ready_o), 264'(1));

    for (int i = 0; i < NIN; i++) v[i] = 8'($urandom);
    push_bytes(v, NIN, 1'b0);
    finish_vector(v, -1, 1'b0, "v8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
